serial_adder: RTL and testbench

Bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock. It is built around the team's one-bit full-adder cell (F_Adder) plus a carry flip-flop. It sits directly upstream of any consumer that needs a registered sum. It trades area for latency: one full-adder cell serves any WIDTH.

---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder around one full-adder cell; ovf logic is built only with SERIAL_ADDER_OVF_EN.
// Latency: WIDTH clock edges from the accepting edge to done. Backpressure: start is ignored while busy or done (no queuing).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_s;
  logic             cell_c;
  logic             last;

  // One-bit full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] f_adder(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign {cell_c, cell_s} = f_adder(a_sh[0], b_sh[0], carry);
  assign last             = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry  <= cell_c;
          sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          // cnt parks at WIDTH-1; the final bit publishes straight from the cell
          if (last) begin
            sum  <= {cell_s, sum_sh[WIDTH-1:1]};
            cout <= cell_c;
          end else begin
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB is the carry register during the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf <= 1'b0;
    else if (state == RUN && last)  ovf <= carry ^ cell_c;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: scoreboard of expected sums, immediate-assertion checks.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] f;
    exp_t       e;
    f      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = f[W-1:0];
    e.cout = f[W];
`ifdef SERIAL_ADDER_OVF_EN
    e.ovf  = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // Requires the DUT to be idle; returns #1 after the accepting edge.
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    push(x, y, c);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares; returns #1 after the edge after done.
  task automatic expect_done(input string tag, input int lat, input bit chk_lat);
    int   n;
    bit   busy_ok;
    exp_t e;
    n = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && n < 64) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (chk_lat) begin
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    end
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"},  32'(sum),  32'(e.sum));
      check({tag, "_cout"}, 32'(cout), 32'(e.cout));
      check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
    end
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int extra_done;
    int extra_busy;
    bit stable_ok;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    int           n;
    exp_t         e;

    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    drive_start(8'h5A, 8'h3C, 1'b0);
    expect_done("add_5a_3c", W, 1'b1);
    drive_start(8'hFF, 8'h01, 1'b0);
    expect_done("add_ff_01", W, 1'b1);
    drive_start(8'h00, 8'h00, 1'b1);
    expect_done("add_cin", W, 1'b1);
    drive_start(8'h7F, 8'h00, 1'b1);
    expect_done("add_7f_cin", W, 1'b1);

    // A second request arriving in RUN cycle 3 must be dropped.
    drive_start(8'h10, 8'h20, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect_done("ignore", W - 3, 1'b1);
    extra_done = 0; extra_busy = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    check("ignore_no_extra_done", 32'(extra_done), 32'd0);
    check("ignore_no_extra_busy", 32'(extra_busy), 32'd0);

    // Reset in RUN cycle 4 abandons the operation.
    drive_start(8'h33, 8'h44, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    @(posedge clk); #1;
    check("midrst_hold_done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive_start(8'h01, 8'h02, 1'b0);
    expect_done("post_rst", W, 1'b1);

    // start held high: each result checked, done one cycle wide, outputs stable between pulses.
    @(negedge clk);
    a = 8'hC8; b = 8'h64; cin = 1'b0; start = 1'b1;
    push(a, b, cin);
    stable_ok = 1'b1;
    prev_sum = sum; prev_cout = cout;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      @(posedge clk); #1;
      while (done !== 1'b1 && n < 64) begin
        if (sum !== prev_sum || cout !== prev_cout) stable_ok = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      check("held_done_seen", 32'(done), 32'd1);
      check("held_sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("held_sum",  32'(sum),  32'(e.sum));
        check("held_cout", 32'(cout), 32'(e.cout));
        check("held_ovf",  32'(ovf),  32'(e.ovf));
      end
      prev_sum = sum; prev_cout = cout;
      if (r < 2) begin
        a = W'(8'h11 * (r + 3)); b = W'(8'hF0 - 8'(r)); cin = 1'(r);
        push(a, b, cin);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      check("held_done_width", 32'(done), 32'd0);
    end
    check("held_outputs_stable", 32'(stable_ok), 32'd1);
    repeat (W + 2) @(posedge clk);
    #1;
    check("held_no_trailing_op", 32'(busy | done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
